// File: rtl/spi_master_upr_pkg.sv
// Shared definitions for the SPI master and slave-side blocks:
// header layout and FSM state encodings.
package spi_master_upr_pkg;

  // Header byte layout: {rw, adr[6:0]}
  localparam int RW_BIT = 7;
  localparam int ADR_W  = 7;
  localparam int HDR_W  = 8;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  // Build the header byte from the direction flag and slave address
  function automatic logic [HDR_W-1:0] make_header(input logic rw,
                                                   input logic [ADR_W-1:0] adr);
    logic [HDR_W-1:0] h;
    h              = '0;
    h[RW_BIT]      = rw;
    h[ADR_W-1:0]   = adr;
    return h;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: while enabled, counts HALF clk cycles per
// phase and flags the first and last cycle of each phase.
module spi_tick_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic first
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  assign tick  = en && (cnt == CW'(HALF - 1));
  assign first = en && (cnt == '0);

  // Phase counter: held at zero while disabled, wraps at the end of each phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      // NOTE: registers are always updated with <= so every flop samples pre-edge values.
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_upr.sv
// SPI master: sends a header byte {rw, adr} followed by Nbit data bits,
// MSB first, with programmable sclk half-period and minimum cs-high gap.
module spi_master_upr
  import spi_master_upr_pkg::*;
#(
  parameter int Nbit   = 8,
  parameter int HALF   = 4,
  parameter int CS_GAP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [ADR_W-1:0] adr,
  input  logic [Nbit-1:0]  wdata,
  output logic             busy,
  output logic             done,
  output logic [Nbit-1:0]  rdata,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs
);

  localparam int TOT = HDR_W + Nbit;
  localparam int BCW = $clog2(TOT);
  localparam int GCW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t          state;
  logic [TOT-2:0]  shreg;    // bits still to be sent after the one on mosi
  logic [Nbit-1:0] rx;       // read data being assembled
  logic [BCW-1:0]  bit_cnt;  // index of the current sclk period
  logic [GCW-1:0]  gap_cnt;
  logic            rw_q;
  logic            armed;    // blocks start on the first edge after reset
  logic            tick_en;
  logic            tick;
  logic            phase_first;
  logic [TOT-1:0]  frame_w;

  // Complete outgoing frame; read frames carry zeros in the data phase
  assign frame_w = {make_header(rw, adr), (rw ? wdata : {Nbit{1'b0}})};

  assign tick_en = (state inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD});

  spi_tick_gen #(
    .HALF (HALF)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (tick_en),
    .tick  (tick),
    .first (phase_first)
  );

  // Frame sequencer with registered SPI outputs, shifters and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rw_q    <= 1'b0;
      armed   <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && armed) begin
            mosi    <= frame_w[TOT-1];
            shreg   <= frame_w[TOT-2:0];
            rw_q    <= rw;
            bit_cnt <= '0;
            rx      <= '0;
            cs      <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= SHIFT_HI;
          end
        end

        SHIFT_HI: begin
          if (phase_first && !rw_q && (bit_cnt >= BCW'(HDR_W))) begin
            rx <= Nbit'({rx, miso});
          end
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt == BCW'(TOT - 1)) begin
              mosi  <= 1'b0;
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi    <= shreg[TOT-2];
              shreg   <= shreg << 1;
              state   <= SHIFT_LO;
            end
          end
        end

        SHIFT_LO: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= SHIFT_HI;
          end
        end

        HOLD: begin
          if (tick) begin
            cs      <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          // done and the busy drop land on the last GAP cycle
          if (gap_cnt == GCW'(CS_GAP - 2)) begin
            done <= 1'b1;
            busy <= 1'b0;
            if (!rw_q) begin
              rdata <= rx;
            end
          end
          if (gap_cnt == GCW'(CS_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
